mpuc_const_cmul: RTL and testbench

Parametrised constant complex multiplier for the FFT butterfly datapath. It scales one complex sample by a run-time selectable twiddle constant (1/√2, 0.5412, 1.3066 or 1.0) and can optionally multiply the result by −j. Real and imaginary parts share one product path over two enabled cycles. Output is round-half-up, saturated and flagged, and sits between butterfly stages under the same ED clock-enable and DS strobe scheme as the rest of the FFT.

---
 rtl/mpuc_const_cmul_if.sv | 26 ++
 rtl/mpuc_const_cmul.sv | 146 ++++++++++++++
 tb/tb_mpuc_const_cmul.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mpuc_const_cmul_if.sv
// Sample/result bundle for the constant complex multiplier: ED/DS strobes,
// twiddle select, complex input sample and the registered complex result.
interface mpuc_const_cmul_if #(
  parameter int WIDTH = 16
);
  logic             ED;
  logic             DS;
  logic [1:0]       KSEL;
  logic             MPYJ;
  logic [WIDTH-1:0] DR;
  logic [WIDTH-1:0] DI;
  logic [WIDTH-1:0] DOR;
  logic [WIDTH-1:0] DOI;
  logic             RDY;
  logic             OVF;

  modport master (
    output ED, DS, KSEL, MPYJ, DR, DI,
    input  DOR, DOI, RDY, OVF
  );

  modport slave (
    input  ED, DS, KSEL, MPYJ, DR, DI,
    output DOR, DOI, RDY, OVF
  );
endinterface

// File: rtl/mpuc_const_cmul.sv
// Constant complex multiplier: one shared multiply/round/saturate path handles
// the real part on the DS edge and the stored imaginary part on the next edge.
module mpuc_const_cmul #(
  parameter int WIDTH = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  mpuc_const_cmul_if.slave  bus
);
  localparam int PW = WIDTH + 16;
  localparam int RW = WIDTH + 3;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [RW-1:0]    SAT_HI = RW'(MAXV);
  localparam logic signed [RW-1:0]    SAT_LO = RW'(MINV);
  localparam logic signed [PW:0]      RND_BIAS = (PW+1)'(8192);

  function automatic logic signed [15:0] kcode(input logic [1:0] sel);
    case (sel)
      2'd0:    kcode = 16'sd11585;
      2'd1:    kcode = 16'sd8867;
      2'd2:    kcode = 16'sd21407;
      default: kcode = 16'sd16384;
    endcase
  endfunction

  // stage 1: real result plus the captured imaginary operand and controls
  logic                    v1_q, v1_d;
  logic signed [WIDTH-1:0] re1_q, re1_d;
  logic                    ovre1_q, ovre1_d;
  logic signed [WIDTH-1:0] di1_q, di1_d;
  logic [1:0]              ks1_q, ks1_d;
  logic                    mj1_q, mj1_d;
  // stage 2: both parts rounded and saturated
  logic                    v2_q, v2_d;
  logic signed [WIDTH-1:0] re2_q, re2_d;
  logic signed [WIDTH-1:0] im2_q, im2_d;
  logic                    ovf2_q, ovf2_d;
  logic                    mj2_q, mj2_d;
  // stage 3: -j rotation applied
  logic                    v3_q, v3_d;
  logic signed [WIDTH-1:0] or3_q, or3_d;
  logic signed [WIDTH-1:0] oi3_q, oi3_d;
  logic                    ovf3_q, ovf3_d;
  // output registers
  logic signed [WIDTH-1:0] dor_q, dor_d;
  logic signed [WIDTH-1:0] doi_q, doi_d;
  logic                    rdy_q, rdy_d;
  logic                    ovf_q, ovf_d;

  logic                    sel_im;
  logic signed [WIDTH-1:0] mul_x;
  logic signed [15:0]      mul_k;
  logic signed [PW-1:0]    prod;
  logic signed [PW:0]      rnd;
  logic signed [RW-1:0]    r_full;
  logic signed [WIDTH-1:0] r_sat;
  logic                    r_ovf;
  logic                    neg_ovf;
  logic signed [WIDTH-1:0] neg_re;

  // A fresh DS claims the shared path, which is what drops the older sample.
  always_comb begin
    sel_im = v1_q & ~bus.DS;
    mul_x  = sel_im ? di1_q : $signed(bus.DR);
    mul_k  = kcode(sel_im ? ks1_q : bus.KSEL);
    prod   = PW'(mul_x) * PW'(mul_k);
    rnd    = (PW+1)'(prod) + RND_BIAS;
    r_full = RW'(rnd >>> 14);
    r_sat  = r_full[WIDTH-1:0];
    r_ovf  = 1'b0;
    if (r_full > SAT_HI) begin
      r_sat = MAXV;
      r_ovf = 1'b1;
    end else if (r_full < SAT_LO) begin
      r_sat = MINV;
      r_ovf = 1'b1;
    end
    neg_ovf = (re2_q == MINV);
    neg_re  = neg_ovf ? MAXV : -re2_q;
  end

  always_comb begin
    v1_d = v1_q;  re1_d = re1_q;  ovre1_d = ovre1_q;
    di1_d = di1_q;  ks1_d = ks1_q;  mj1_d = mj1_q;
    v2_d = v2_q;  re2_d = re2_q;  im2_d = im2_q;  ovf2_d = ovf2_q;  mj2_d = mj2_q;
    v3_d = v3_q;  or3_d = or3_q;  oi3_d = oi3_q;  ovf3_d = ovf3_q;
    dor_d = dor_q;  doi_d = doi_q;  rdy_d = rdy_q;  ovf_d = ovf_q;
    if (bus.ED) begin
      v1_d = bus.DS;
      if (bus.DS) begin
        re1_d   = r_sat;
        ovre1_d = r_ovf;
        di1_d   = $signed(bus.DI);
        ks1_d   = bus.KSEL;
        mj1_d   = bus.MPYJ;
      end
      v2_d = sel_im;
      if (sel_im) begin
        re2_d  = re1_q;
        im2_d  = r_sat;
        ovf2_d = ovre1_q | r_ovf;
        mj2_d  = mj1_q;
      end
      v3_d = v2_q;
      if (v2_q) begin
        if (mj2_q) begin
          or3_d  = im2_q;
          oi3_d  = neg_re;
          ovf3_d = ovf2_q | neg_ovf;
        end else begin
          or3_d  = re2_q;
          oi3_d  = im2_q;
          ovf3_d = ovf2_q;
        end
      end
      rdy_d = v3_q;
      if (v3_q) begin
        dor_d = or3_q;
        doi_d = oi3_q;
        ovf_d = ovf_q | ovf3_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v1_q <= 1'b0;  re1_q <= '0;  ovre1_q <= 1'b0;
      di1_q <= '0;  ks1_q <= '0;  mj1_q <= 1'b0;
      v2_q <= 1'b0;  re2_q <= '0;  im2_q <= '0;  ovf2_q <= 1'b0;  mj2_q <= 1'b0;
      v3_q <= 1'b0;  or3_q <= '0;  oi3_q <= '0;  ovf3_q <= 1'b0;
      dor_q <= '0;  doi_q <= '0;  rdy_q <= 1'b0;  ovf_q <= 1'b0;
    end else begin
      v1_q <= v1_d;  re1_q <= re1_d;  ovre1_q <= ovre1_d;
      di1_q <= di1_d;  ks1_q <= ks1_d;  mj1_q <= mj1_d;
      v2_q <= v2_d;  re2_q <= re2_d;  im2_q <= im2_d;  ovf2_q <= ovf2_d;  mj2_q <= mj2_d;
      v3_q <= v3_d;  or3_q <= or3_d;  oi3_q <= oi3_d;  ovf3_q <= ovf3_d;
      dor_q <= dor_d;  doi_q <= doi_d;  rdy_q <= rdy_d;  ovf_q <= ovf_d;
    end
  end

  assign bus.DOR = dor_q;
  assign bus.DOI = doi_q;
  assign bus.RDY = rdy_q;
  assign bus.OVF = ovf_q;
endmodule

// File: tb/tb_mpuc_const_cmul.sv
// Randomized bench for mpuc_const_cmul against an arithmetic reference model
// that tracks accepted samples by enabled-edge index.
module tb_mpuc_const_cmul;
  localparam int     W    = 16;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  mpuc_const_cmul_if #(.WIDTH(W)) bus ();
  mpuc_const_cmul #(.WIDTH(W)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  typedef struct {
    int     due;
    longint dor;
    longint doi;
    bit     ovf;
  } res_t;

  res_t   pq[$];
  int     n_tests  = 0;
  int     n_fail   = 0;
  int     edge_cnt = 0;
  bit     exp_rdy  = 1'b0;
  longint exp_dor  = 0;
  longint exp_doi  = 0;
  bit     exp_ovf  = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint kval(input int sel);
    case (sel)
      0:       return 11585;
      1:       return 8867;
      2:       return 21407;
      default: return 16384;
    endcase
  endfunction

  function automatic longint clamp(input longint v, inout bit ov);
    if (v > MAXV) begin ov = 1'b1; return MAXV; end
    if (v < MINV) begin ov = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic res_t ref_sample(input int ks, input bit mj, input longint dr, input longint di);
    res_t   r;
    bit     ov = 1'b0;
    longint re = clamp((dr * kval(ks) + 8192) >>> 14, ov);
    longint im = clamp((di * kval(ks) + 8192) >>> 14, ov);
    r.due = 0;
    if (mj) begin
      r.dor = im;
      r.doi = clamp(-re, ov);
    end else begin
      r.dor = re;
      r.doi = im;
    end
    r.ovf = ov;
    return r;
  endfunction

  task automatic check_all();
    check("rdy", longint'(bus.RDY), longint'(exp_rdy));
    check("dor", longint'($signed(bus.DOR)), exp_dor);
    check("doi", longint'($signed(bus.DOI)), exp_doi);
    check("ovf", longint'(bus.OVF), longint'(exp_ovf));
  endtask

  task automatic cycle(input bit ed, input bit ds, input int ks, input bit mj,
                       input longint dr, input longint di);
    res_t r;
    bus.ED   = ed;
    bus.DS   = ds;
    bus.KSEL = 2'(ks);
    bus.MPYJ = mj;
    bus.DR   = W'(dr);
    bus.DI   = W'(di);
    @(posedge CLK);
    #1;
    if (ed) begin
      edge_cnt++;
      exp_rdy = 1'b0;
      if (pq.size() > 0 && pq[0].due == edge_cnt) begin
        r = pq.pop_front();
        exp_rdy = 1'b1;
        exp_dor = r.dor;
        exp_doi = r.doi;
        exp_ovf = exp_ovf | r.ovf;
      end
      if (ds) begin
        // a sample accepted on the previous enabled edge never finishes
        if (pq.size() > 0 && pq[pq.size()-1].due == edge_cnt + 2)
          void'(pq.pop_back());
        r = ref_sample(ks, mj, dr, di);
        r.due = edge_cnt + 3;
        pq.push_back(r);
      end
    end
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic send(input int ks, input bit mj, input longint dr, input longint di);
    cycle(1'b1, 1'b1, ks, mj, dr, di);
    idle(3);
  endtask

  task automatic expect_out(input string tag, input longint dor, input longint doi, input bit ovf);
    check({tag, "_rdy"}, longint'(bus.RDY), 1);
    check({tag, "_dor"}, longint'($signed(bus.DOR)), dor);
    check({tag, "_doi"}, longint'($signed(bus.DOI)), doi);
    check({tag, "_ovf"}, longint'(bus.OVF), longint'(ovf));
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #2;
    check("rst_dor", longint'($signed(bus.DOR)), 0);
    check("rst_doi", longint'($signed(bus.DOI)), 0);
    check("rst_rdy", longint'(bus.RDY), 0);
    check("rst_ovf", longint'(bus.OVF), 0);
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    pq.delete();
    exp_rdy = 1'b0;
    exp_dor = 0;
    exp_doi = 0;
    exp_ovf = 1'b0;
  endtask

  initial begin
    longint dr, di;
    bus.ED = 1'b0; bus.DS = 1'b0; bus.KSEL = 2'd0; bus.MPYJ = 1'b0;
    bus.DR = '0;   bus.DI = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    @(negedge CLK);
    RSTN = 1'b1;

    send(3, 1'b0, 1000, -2000);
    expect_out("unity", 1000, -2000, 1'b0);
    idle(1);
    send(0, 1'b0, 16384, -16384);
    expect_out("k0", 11585, -11585, 1'b0);
    send(1, 1'b0, 3, -3);
    expect_out("k1_round", 2, -2, 1'b0);
    send(2, 1'b0, 32767, -32768);
    expect_out("k2_sat", 32767, -32768, 1'b1);
    send(3, 1'b0, 5, 5);
    expect_out("ovf_sticky", 5, 5, 1'b1);

    // ED gap inside the pipeline
    cycle(1'b1, 1'b1, 0, 1'b0, 1234, -777);
    idle(1);
    repeat (5) cycle(1'b0, 1'b0, 0, 1'b0, 0, 0);
    idle(2);
    expect_out("ed_gap", 873, -549, 1'b1);

    // back-to-back DS: only the later sample completes
    cycle(1'b1, 1'b1, 3, 1'b0, 111, 222);
    cycle(1'b1, 1'b1, 3, 1'b1, 50, -60);
    idle(3);
    expect_out("double_ds", -60, -50, 1'b1);
    idle(2);

    // reset mid-pipeline
    cycle(1'b1, 1'b1, 2, 1'b0, 32767, 0);
    idle(1);
    do_reset();
    idle(4);
    send(3, 1'b0, 7, -8);
    expect_out("post_rst", 7, -8, 1'b0);

    send(3, 1'b1, -32768, 100);
    expect_out("mpyj_neg_sat", 100, 32767, 1'b1);
    idle(2);

    repeat (600) begin
      if ($urandom_range(0, 3) == 0) dr = ($urandom_range(0, 1) != 0) ? MAXV : MINV;
      else dr = longint'($signed(16'($urandom)));
      if ($urandom_range(0, 3) == 0) di = ($urandom_range(0, 1) != 0) ? MAXV : MINV;
      else di = longint'($signed(16'($urandom)));
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
            int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, dr, di);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
